// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues load/store bus transactions with byte-lane
// steering and load extension, and produces the single-cycle register writeback.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_exec_stall,
  input  logic        i_fetch_stall,
  output logic        o_mem_stall,
  input  logic [5:0]  i_op,
  input  logic [4:0]  i_dst_gpr,
  input  logic [31:0] i_result,
  input  logic [31:0] i_mem_data,
  output logic        o_rt_wr,
  output logic [4:0]  o_rt,
  output logic [31:0] o_rt_data,
  output logic        o_mem_err,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ack,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {IDLE, REQ, RDATA} state_t;

  state_t      state, state_nxt;
  logic        is_load, is_store, misalign, capture, load_done;
  logic [5:0]  op_p1;
  logic [1:0]  lane_p1;

  function automatic logic [3:0] lane_be(input logic [5:0] op, input logic [1:0] a);
    case (op)
      OP_LB, OP_LBU, OP_SB: lane_be = 4'b0001 << a;
      OP_LH, OP_LHU, OP_SH: lane_be = a[1] ? 4'b1100 : 4'b0011;
      default:              lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [5:0] op, input logic [31:0] d);
    case (op)
      OP_SB:   lane_wdata = {4{d[7:0]}};
      OP_SH:   lane_wdata = {2{d[15:0]}};
      default: lane_wdata = d;
    endcase
  endfunction

  // Lane shift first, then extend; halfword lanes are aligned so a[0] is 0.
  function automatic logic [31:0] load_extend(input logic [5:0] op, input logic [1:0] a,
                                              input logic [31:0] rd);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    sh = rd >> {a, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (op)
      OP_LB:   load_extend = {{24{b[7]}}, b};
      OP_LBU:  load_extend = {24'b0, sh[7:0]};
      OP_LH:   load_extend = {{16{h[15]}}, h};
      OP_LHU:  load_extend = {16'b0, sh[15:0]};
      default: load_extend = rd;
    endcase
  endfunction

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    misalign = 1'b0;
    case (i_op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: is_load  = 1'b1;
      OP_SB, OP_SH, OP_SW:                 is_store = 1'b1;
      default: ;
    endcase
    case (i_op)
      OP_LH, OP_LHU, OP_SH: misalign = i_result[0];
      OP_LW, OP_SW:         misalign = |i_result[1:0];
      default: ;
    endcase
  end

  assign o_mem_stall = (state != IDLE);
  assign capture     = (state == IDLE) & ~(o_mem_stall | i_exec_stall | i_fetch_stall);

  always_comb begin
    state_nxt = state;
    load_done = 1'b0;
    case (state)
      IDLE:  if (capture && (is_load || is_store) && !misalign) state_nxt = REQ;
      REQ: begin
        if (i_bus_ack) begin
          if (o_bus_we) begin
            state_nxt = IDLE;
          end else if (i_bus_rvalid) begin
            state_nxt = IDLE;
            load_done = 1'b1;
          end else begin
            state_nxt = RDATA;
          end
        end
      end
      RDATA: begin
        if (i_bus_rvalid) begin
          state_nxt = IDLE;
          load_done = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // p1: captured request context, used when the transaction completes
  always_ff @(posedge clk) begin
    if (capture) begin
      op_p1   <= i_op;
      lane_p1 <= i_result[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_rt_wr     <= 1'b0;
      o_rt        <= 5'd0;
      o_rt_data   <= 32'd0;
      o_mem_err   <= 1'b0;
      o_bus_req   <= 1'b0;
      o_bus_we    <= 1'b0;
      o_bus_addr  <= 32'd0;
      o_bus_be    <= 4'd0;
      o_bus_wdata <= 32'd0;
    end else begin
      o_rt_wr   <= 1'b0;
      o_mem_err <= 1'b0;
      if (capture) begin
        if (!(is_load || is_store)) begin
          o_rt_wr   <= (i_dst_gpr != 5'd0);
          o_rt      <= i_dst_gpr;
          o_rt_data <= i_result;
        end else if (misalign) begin
          o_mem_err <= 1'b1;
        end else begin
          o_bus_req   <= 1'b1;
          o_bus_we    <= is_store;
          o_bus_addr  <= {i_result[31:2], 2'b00};
          o_bus_be    <= lane_be(i_op, i_result[1:0]);
          o_bus_wdata <= lane_wdata(i_op, i_mem_data);
          o_rt        <= i_dst_gpr;
        end
      end
      if (state == REQ && i_bus_ack) o_bus_req <= 1'b0;
      if (load_done) begin
        o_rt_wr   <= (o_rt != 5'd0);
        o_rt_data <= load_extend(op_p1, lane_p1, i_bus_rdata);
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed cases plus randomized ops against an arithmetic
// model of sizes, lane offsets and sign extension.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_exec_stall, i_fetch_stall;
  logic        o_mem_stall;
  logic [5:0]  i_op;
  logic [4:0]  i_dst_gpr;
  logic [31:0] i_result, i_mem_data;
  logic        o_rt_wr;
  logic [4:0]  o_rt;
  logic [31:0] o_rt_data;
  logic        o_mem_err, o_bus_req, o_bus_we;
  logic [31:0] o_bus_addr;
  logic [3:0]  o_bus_be;
  logic [31:0] o_bus_wdata;
  logic        i_bus_ack, i_bus_rvalid;
  logic [31:0] i_bus_rdata;

  int ncmp  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst(rst), .i_exec_stall(i_exec_stall), .i_fetch_stall(i_fetch_stall),
    .o_mem_stall(o_mem_stall), .i_op(i_op), .i_dst_gpr(i_dst_gpr), .i_result(i_result),
    .i_mem_data(i_mem_data), .o_rt_wr(o_rt_wr), .o_rt(o_rt), .o_rt_data(o_rt_data),
    .o_mem_err(o_mem_err), .o_bus_req(o_bus_req), .o_bus_we(o_bus_we),
    .o_bus_addr(o_bus_addr), .o_bus_be(o_bus_be), .o_bus_wdata(o_bus_wdata),
    .i_bus_ack(i_bus_ack), .i_bus_rvalid(i_bus_rvalid), .i_bus_rdata(i_bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_op         = 6'h00;
    i_dst_gpr    = 5'd0;
    i_result     = 32'd0;
    i_mem_data   = 32'd0;
    i_bus_ack    = 1'b0;
    i_bus_rvalid = 1'b0;
    i_bus_rdata  = $urandom;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rt_wr"}, o_rt_wr, 0);
    chk({tag, "_rt"}, o_rt, 0);
    chk({tag, "_rt_data"}, o_rt_data, 0);
    chk({tag, "_err"}, o_mem_err, 0);
    chk({tag, "_req"}, o_bus_req, 0);
    chk({tag, "_we"}, o_bus_we, 0);
    chk({tag, "_addr"}, o_bus_addr, 0);
    chk({tag, "_be"}, o_bus_be, 0);
    chk({tag, "_wdata"}, o_bus_wdata, 0);
    chk({tag, "_stall"}, o_mem_stall, 0);
  endtask

  // Issue one op with the stage idle; ack comes ack_dly cycles after the request
  // appears, rvalid rv_dly cycles after ack (0 = same cycle).
  task automatic run_op(input logic [5:0] op, input logic [4:0] dst, input logic [31:0] res,
                        input logic [31:0] d, input int ack_dly, input int rv_dly,
                        input logic [31:0] rdata, input bit rand_stall);
    int size, off, last;
    bit ld, sgn, mis;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_ld;
    longint v;
    size = 0; ld = 0; sgn = 0;
    case (op)
      6'h20: begin size = 1; ld = 1; sgn = 1; end
      6'h21: begin size = 2; ld = 1; sgn = 1; end
      6'h23: begin size = 4; ld = 1; end
      6'h24: begin size = 1; ld = 1; end
      6'h25: begin size = 2; ld = 1; end
      6'h28: size = 1;
      6'h29: size = 2;
      6'h2B: size = 4;
      default: size = 0;
    endcase
    off    = int'(res[1:0]);
    mis    = (size != 0) && ((off % size) != 0);
    exp_be = 4'(((1 << size) - 1) << off);
    exp_wd = (size == 1) ? d[7:0] * 32'h01010101 :
             (size == 2) ? d[15:0] * 32'h00010001 : d;
    v = longint'(rdata >> (8 * off)) & ((longint'(1) << (8 * size)) - 1);
    if (sgn && v >= (longint'(1) << (8 * size - 1))) v = v - (longint'(1) << (8 * size));
    exp_ld = 32'(v);

    i_op = op; i_dst_gpr = dst; i_result = res; i_mem_data = d;
    step();
    idle_inputs();
    if (size == 0) begin
      chk("pt_wr", o_rt_wr, dst != 0);
      if (dst != 0) begin
        chk("pt_rt", o_rt, dst);
        chk("pt_data", o_rt_data, res);
      end
      chk("pt_req", o_bus_req, 0);
      chk("pt_stall", o_mem_stall, 0);
      step();
      chk("pt_pulse", o_rt_wr, 0);
    end else if (mis) begin
      chk("mis_err", o_mem_err, 1);
      chk("mis_req", o_bus_req, 0);
      chk("mis_stall", o_mem_stall, 0);
      chk("mis_wr", o_rt_wr, 0);
      step();
      chk("mis_pulse", o_mem_err, 0);
      chk("mis_req2", o_bus_req, 0);
    end else begin
      last = ld ? ack_dly + rv_dly : ack_dly;
      for (int c = 0; c <= last; c++) begin
        chk("bus_stall", o_mem_stall, 1);
        chk("bus_wr_busy", o_rt_wr, 0);
        if (c <= ack_dly) begin
          chk("bus_req", o_bus_req, 1);
          chk("bus_addr", o_bus_addr, res & ~32'd3);
          chk("bus_we", o_bus_we, !ld);
          chk("bus_be", o_bus_be, exp_be);
          if (!ld) chk("bus_wdata", o_bus_wdata, exp_wd);
        end else begin
          chk("bus_req_drop", o_bus_req, 0);
        end
        i_bus_ack    = (c == ack_dly);
        i_bus_rvalid = ld && (c == last);
        i_bus_rdata  = (ld && c == last) ? rdata : $urandom;
        if (rand_stall) begin
          i_exec_stall  = 1'($urandom_range(0, 1));
          i_fetch_stall = 1'($urandom_range(0, 1));
        end
        step();
      end
      i_bus_ack = 1'b0; i_bus_rvalid = 1'b0;
      i_exec_stall = 1'b0; i_fetch_stall = 1'b0;
      chk("done_stall", o_mem_stall, 0);
      chk("done_req", o_bus_req, 0);
      chk("wb_wr", o_rt_wr, ld && dst != 0);
      if (ld && dst != 0) begin
        chk("wb_rt", o_rt, dst);
        chk("wb_data", o_rt_data, exp_ld);
      end
      step();
      chk("wb_pulse", o_rt_wr, 0);
    end
  endtask

  initial begin
    logic [5:0] ops [12];
    logic [31:0] addr;
    ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B,
            6'h00, 6'h09, 6'h22, 6'h2A};
    rst = 1'b1; i_exec_stall = 1'b0; i_fetch_stall = 1'b0;
    idle_inputs();
    step();
    step();
    chk_all_zero("reset");
    rst = 1'b0;

    run_op(6'h21 + 6'h00 - 6'h21 + 6'h09, 5'd5, 32'h1234, 32'h0, 0, 0, 32'h0, 1'b0);
    run_op(6'h28, 5'd3, 32'h103, 32'hAABBCCDD, 3, 0, 32'h0, 1'b0);
    run_op(6'h20, 5'd4, 32'h202, 32'h0, 0, 0, 32'h00800000, 1'b0);
    run_op(6'h24, 5'd4, 32'h202, 32'h0, 0, 0, 32'h00800000, 1'b0);
    run_op(6'h21, 5'd6, 32'h302, 32'h0, 0, 2, 32'h8001ABCD, 1'b0);
    run_op(6'h23, 5'd8, 32'h402, 32'h0, 0, 0, 32'h0, 1'b0);
    run_op(6'h23, 5'd0, 32'h600, 32'h0, 1, 1, 32'hCAFEF00D, 1'b0);
    run_op(6'h00, 5'd0, 32'h77, 32'h0, 0, 0, 32'h0, 1'b0);

    // Idle stage with an upstream stall must not capture or write back.
    i_exec_stall = 1'b1; i_op = 6'h00; i_dst_gpr = 5'd9; i_result = 32'h55;
    step();
    chk("bubble_wr0", o_rt_wr, 0);
    step();
    chk("bubble_wr1", o_rt_wr, 0);
    i_exec_stall = 1'b0;
    step();
    chk("bubble_release_wr", o_rt_wr, 1);
    chk("bubble_release_data", o_rt_data, 32'h55);
    idle_inputs();
    step();
    chk("bubble_release_pulse", o_rt_wr, 0);

    // Reset while waiting for read data abandons the load.
    i_op = 6'h23; i_dst_gpr = 5'd7; i_result = 32'h500;
    step();
    idle_inputs();
    i_bus_ack = 1'b1;
    step();
    i_bus_ack = 1'b0;
    chk("rdata_wait_stall", o_mem_stall, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_all_zero("mid_rst");
    i_bus_rvalid = 1'b1; i_bus_rdata = 32'h12345678;
    step();
    i_bus_rvalid = 1'b0;
    chk("late_rvalid_wr", o_rt_wr, 0);
    chk("late_rvalid_stall", o_mem_stall, 0);
    chk("late_rvalid_data", o_rt_data, 0);

    for (int n = 0; n < 40; n++) begin
      addr = $urandom;
      if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
      run_op(ops[$urandom_range(0, 11)], 5'($urandom_range(0, 31)), addr, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
